serial_add_ctrl: RTL and testbench

- Sequencer for a single `fa` full-adder cell. Performs a W-bit add or subtract bit-serially, LSB first, one bit per clock.
- Trades latency for area in the CombiCalcs arithmetic path.
- Accepts operands through a valid/ready request handshake and returns result, carry-out and signed overflow through a valid/ready response handshake.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/serial_add_ctrl_if.sv | 39 +++
 rtl/fa.sv | 20 ++
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the CombiCalcs bit-serial arithmetic path.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   DEFAULT_W : default operand/result width
//   OP_ADD/OP_SUB : encoding of the 'sub' request bit
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : calc_pkg

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/response bundle of the bit-serial adder sequencer.
//   Request  : start_valid/start_ready handshake carrying a_in, b_in, sub
//   Response : res_valid/res_ready handshake carrying result, cout, ovf
//   Status   : busy (operation in flight or waiting to be collected)
// Modports:
//   master : requester/consumer side (drives operands and res_ready)
//   slave  : sequencer side (drives ready, response and status)
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if
    import calc_pkg::*;
#(
    parameter int W = DEFAULT_W
);

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output start_valid, a_in, b_in, sub, res_ready,
        input  start_ready, res_valid, result, cout, ovf, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, sub, res_ready,
        output start_ready, res_valid, result, cout, ovf, busy
    );

endinterface : serial_add_ctrl_if

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa
// Single-bit full adder cell.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial W-bit add/subtract built around one full-adder cell. Operands are
// consumed LSB first, one bit per clock, so a result appears W cycles after the
// request is accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_ctrl_if.slave (request, response and busy status)
// Subtraction is A + ~B + 1: B is inverted at load and the carry flop is
// preset to 1. cout is therefore "no borrow" for subtracts.
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import calc_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int             CW   = $clog2(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sh_q,  a_sh_d;
    logic [W-1:0]   b_sh_q,  b_sh_d;
    // Only W-1 sum bits need storing: the MSB sum comes straight from the
    // adder on the final RUN cycle.
    logic [W-2:0]   acc_q,   acc_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q,  cout_d;
    logic           ovf_q,   ovf_d;

    logic           fa_s;
    logic           fa_co;

    fa u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the
        // case below can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = (bus.sub == OP_SUB) ? ~bus.b_in : bus.b_in;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = (acc_q >> 1) | ((W-1)'(fa_s) << (W - 2));
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = {fa_s, acc_q};
                    cout_d   = fa_co;
                    // Signed overflow: carry into the sign bit differs from
                    // carry out of it.
                    ovf_d    = carry_q ^ fa_co;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end

            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the whole datapath is reset, not just the FSM, so an operation
    // aborted by reset leaves no stale operand, carry or result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake and status outputs decode from state only.
    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.result      = result_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Scoreboard bench for serial_add_ctrl. The driver pushes the expected
// response (from an integer-arithmetic model) when a request is accepted; the
// monitor compares every cycle the DUT presents a response and checks that
// outputs hold their last completed value otherwise.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
    import calc_pkg::*;

    localparam int W      = 8;
    localparam int PERIOD = 10;

    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        longint       t_valid;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #(PERIOD/2) clk = ~clk;

    serial_add_ctrl_if #(.W(W)) bus ();

    serial_add_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    exp_t   sb_q[$];
    logic [W-1:0] last_result = '0;
    logic   last_cout  = 1'b0;
    logic   last_ovf   = 1'b0;
    bit     prev_valid = 1'b0;
    bit     rr_random  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int u;
        int sv;
        if (s == OP_SUB) begin
            u      = ua - ub;
            sv     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            u      = ua + ub;
            sv     = sa + sb;
            e.cout = (u >= (1 << W));
        end
        e.result  = u[W-1:0];
        e.ovf     = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
        e.t_valid = 0;
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_start_ready"}, 32'(bus.start_ready), 1);
        check({tag, "_res_valid"},   32'(bus.res_valid),   0);
        check({tag, "_busy"},        32'(bus.busy),        0);
        check({tag, "_result"},      32'(bus.result),      0);
        check({tag, "_cout"},        32'(bus.cout),        0);
        check({tag, "_ovf"},         32'(bus.ovf),         0);
    endtask

    // Present a request and wait (bounded) for acceptance. Returns the time
    // of the accepting edge, or -1 if never accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output longint t_acc);
        exp_t e;
        bit   done = 1'b0;
        e = model(a, b, s);
        bus.a_in        = a;
        bus.b_in        = b;
        bus.sub         = s;
        bus.start_valid = 1'b1;
        t_acc = -1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.start_ready) begin
                @(posedge clk);
                t_acc     = $time;
                e.t_valid = $time + W*PERIOD + PERIOD/2;
                sb_q.push_back(e);
                done = 1'b1;
            end
        end
        #1;
        bus.start_valid = 1'b0;
        check("accept_within_bound", 32'(done), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain_queue_empty", 32'(sb_q.size()), 0);
    endtask

    // Randomised consumer backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rr_random) bus.res_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: response contents, latency, and hold behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid  = 1'b0;
            last_result = '0;
            last_cout   = 1'b0;
            last_ovf    = 1'b0;
        end else if (bus.res_valid) begin
            if (!prev_valid) check("res_valid_has_request", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                if (!prev_valid)
                    check("res_valid_time", 32'($time), 32'(sb_q[0].t_valid));
                check("result",      32'(bus.result),      32'(sb_q[0].result));
                check("cout",        32'(bus.cout),        32'(sb_q[0].cout));
                check("ovf",         32'(bus.ovf),         32'(sb_q[0].ovf));
                check("busy_done",   32'(bus.busy),        1);
                check("ready_done",  32'(bus.start_ready), 0);
                if (bus.res_ready) begin
                    last_result = sb_q[0].result;
                    last_cout   = sb_q[0].cout;
                    last_ovf    = sb_q[0].ovf;
                    void'(sb_q.pop_front());
                end
            end
            prev_valid = 1'b1;
        end else begin
            check("result_held",    32'(bus.result),      32'(last_result));
            check("cout_held",      32'(bus.cout),        32'(last_cout));
            check("ovf_held",       32'(bus.ovf),         32'(last_ovf));
            check("ready_vs_busy",  32'(bus.start_ready), 32'(!bus.busy));
            prev_valid = 1'b0;
        end
    end

    initial begin
        #(50000*PERIOD);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1;
        bit     saw_valid;
        logic [W-1:0] ra, rb;
        logic   rs;

        bus.start_valid = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        bus.sub         = OP_ADD;
        bus.res_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, back-to-back with res_ready held high.
        issue(8'h3C, 8'h5A, OP_ADD, t0);
        issue(8'hFF, 8'h01, OP_ADD, t1);
        check("b2b_spacing_1", 32'(t1 - t0), (W + 2) * PERIOD);
        issue(8'h10, 8'h20, OP_SUB, t0);
        check("b2b_spacing_2", 32'(t0 - t1), (W + 2) * PERIOD);
        issue(8'h80, 8'h01, OP_SUB, t1);
        check("b2b_spacing_3", 32'(t1 - t0), (W + 2) * PERIOD);
        drain();

        // Backpressure: result held, new requests refused while in DONE.
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        issue(8'h7F, 8'h01, OP_ADD, t0);
        for (int k = 0; k < 50 && !bus.res_valid; k++) @(negedge clk);
        check("bp_res_valid_seen", 32'(bus.res_valid), 1);
        for (int k = 0; k < 5; k++) begin
            bus.a_in        = W'($urandom);
            bus.b_in        = W'($urandom);
            bus.sub         = 1'($urandom);
            bus.start_valid = 1'b1;
            @(negedge clk);
            check("bp_start_ready", 32'(bus.start_ready), 0);
            check("bp_res_valid",   32'(bus.res_valid),   1);
        end
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_start_ready", 32'(bus.start_ready), 1);
        check("bp_idle_res_valid",   32'(bus.res_valid),   0);
        @(negedge clk);
        check("bp_no_stale_accept",  32'(bus.busy),        0);

        // Reset in the middle of RUN (bit 3).
        @(posedge clk); #1;
        issue(8'hAA, 8'h55, OP_ADD, t0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_reset_values("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            saw_valid |= bus.res_valid;
        end
        check("no_res_after_reset", 32'(saw_valid), 0);
        @(posedge clk); #1;
        issue(8'h01, 8'h01, OP_ADD, t0);
        drain();

        // Randomised operations with random consumer backpressure.
        rr_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       ra = '0;
                1:       ra = '1;
                2:       ra = {1'b1, {(W-1){1'b0}}};
                3:       ra = {1'b0, {(W-1){1'b1}}};
                default: ra = W'($urandom);
            endcase
            rb = W'($urandom);
            rs = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue(ra, rb, rs, t0);
        end
        drain();
        rr_random = 1'b0;
        @(posedge clk); #2;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_ctrl
